// File: rtl/cam_sched_pkg.sv
// Shared types and helpers for the CAM request scheduler.
package cam_sched_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ISSUE = 2'd1,
    HOLD       = 2'd2
  } sched_state_t;

  localparam logic SEL_LOOKUP = 1'b0;
  localparam logic SEL_UPDATE = 1'b1;

  // Common sideband width: the wider of the two requester user fields.
  function automatic int unsigned user_width(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cam_sched_hold_ctr.sv
// Post-update write-hold counter: loads, counts down to zero, busy stretches completion.
module cam_sched_hold_ctr
  import cam_sched_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 5
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  input  logic i_busy,
  output logic o_done_c
);

  localparam int unsigned CW = cnt_width(HOLD_CYCLES);

  logic [CW-1:0] r_cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(HOLD_CYCLES);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Hold may end only once the count is spent and the CAM write has finished.
  assign o_done_c = (r_cnt == '0) && !i_busy;

endmodule

// File: rtl/cam_req_scheduler.sv
// Arbitrates update and lookup requests onto the single CAM match port.
module cam_req_scheduler
  import cam_sched_pkg::*;
#(
  parameter int unsigned KEY_SIZE          = 8,
  parameter int unsigned VALUE_SIZE        = 32,
  parameter int unsigned UPDATE_USER_WIDTH = 4,
  parameter int unsigned LOOKUP_USER_WIDTH = 4,
  parameter int unsigned WRITE_HOLD_CYCLES = 5,
  parameter int unsigned STARVE_LIMIT      = 4,
  parameter int unsigned LKP_DURING_HOLD   = 1
)
(
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic [KEY_SIZE-1:0]                                         upd_index,
  input  logic [VALUE_SIZE-1:0]                                       upd_data,
  input  logic [UPDATE_USER_WIDTH-1:0]                                upd_user,
  input  logic                                                        upd_valid,
  output logic                                                        upd_ready,
  input  logic [KEY_SIZE-1:0]                                         lkp_index,
  input  logic [LOOKUP_USER_WIDTH-1:0]                                lkp_user,
  input  logic                                                        lkp_valid,
  output logic                                                        lkp_ready,
  output logic [KEY_SIZE+VALUE_SIZE-1:0]                              m_dataindex,
  output logic [user_width(UPDATE_USER_WIDTH, LOOKUP_USER_WIDTH):0]   m_user,
  output logic                                                        m_select,
  output logic                                                        m_valid,
  input  logic                                                        m_ready,
  input  logic                                                        cam_write_busy,
  output logic                                                        hold_active,
  output logic                                                        starve_grant
);

  localparam int unsigned UW = user_width(UPDATE_USER_WIDTH, LOOKUP_USER_WIDTH);
  localparam int unsigned DW = KEY_SIZE + VALUE_SIZE;
  localparam int unsigned SW = cnt_width(STARVE_LIMIT);

  sched_state_t      r_state;
  logic [KEY_SIZE-1:0] r_pend_key;
  logic [SW-1:0]     r_starve_cnt;
  logic [DW-1:0]     r_m_dataindex;
  logic [UW:0]       r_m_user;
  logic              r_m_select;
  logic              r_m_valid;
  logic              r_hold_active;
  logic              r_starve_grant;

  logic              w_slot_free;
  logic              w_upd_gnt;
  logic              w_lkp_gnt;
  logic              w_starve_ovr;
  logic              w_key_conflict;
  logic              w_sel;
  logic [DW-1:0]     w_load_di;
  logic [UW:0]       w_load_user;
  logic              w_issue_upd;
  logic              w_hold_done_c;

  // Grant arbitration: lookup priority, starvation override, hold/hazard gating.
  always_comb begin
    w_slot_free    = !r_m_valid || m_ready;
    w_key_conflict = (lkp_index == r_pend_key);
    w_upd_gnt      = 1'b0;
    w_lkp_gnt      = 1'b0;
    w_starve_ovr   = 1'b0;
    if (rst_n && w_slot_free) begin
      if (r_state == IDLE) begin
        if (upd_valid && lkp_valid) begin
          if (r_starve_cnt == SW'(STARVE_LIMIT)) begin
            w_upd_gnt    = 1'b1;
            w_starve_ovr = 1'b1;
          end else begin
            w_lkp_gnt = 1'b1;
          end
        end else if (upd_valid) begin
          w_upd_gnt = 1'b1;
        end else if (lkp_valid) begin
          w_lkp_gnt = 1'b1;
        end
      end else begin
        w_lkp_gnt = lkp_valid && (LKP_DURING_HOLD != 0) && !w_key_conflict;
      end
    end
  end

  // Payload for the output register from whichever side was granted.
  always_comb begin
    w_sel       = w_upd_gnt ? SEL_UPDATE : SEL_LOOKUP;
    w_load_di   = w_upd_gnt ? {upd_data, upd_index} : {{VALUE_SIZE{1'b0}}, lkp_index};
    w_load_user = w_upd_gnt ? {w_sel, UW'(upd_user)} : {w_sel, UW'(lkp_user)};
  end

  assign w_issue_upd = (r_state == WAIT_ISSUE) && r_m_valid && m_ready && r_m_select;

  cam_sched_hold_ctr #(
    .HOLD_CYCLES (WRITE_HOLD_CYCLES)
  ) u_hold_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_issue_upd),
    .i_dec    (r_state == HOLD),
    .i_busy   (cam_write_busy),
    .o_done_c (w_hold_done_c)
  );

  // Output stage, sequencing FSM and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pend_key     <= '0;
      r_starve_cnt   <= '0;
      r_m_dataindex  <= '0;
      r_m_user       <= '0;
      r_m_select     <= 1'b0;
      r_m_valid      <= 1'b0;
      r_hold_active  <= 1'b0;
      r_starve_grant <= 1'b0;
    end else begin
      r_starve_grant <= w_upd_gnt && w_starve_ovr;

      if (w_upd_gnt || w_lkp_gnt) begin
        r_m_valid     <= 1'b1;
        r_m_select    <= w_sel;
        r_m_dataindex <= w_load_di;
        r_m_user      <= w_load_user;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end

      if (w_upd_gnt || !upd_valid) begin
        r_starve_cnt <= '0;
      end else if (w_lkp_gnt && (r_state == IDLE) && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_upd_gnt) begin
            r_state    <= WAIT_ISSUE;
            r_pend_key <= upd_index;
          end
        end
        WAIT_ISSUE: begin
          if (w_issue_upd) begin
            r_state       <= HOLD;
            r_hold_active <= 1'b1;
          end
        end
        HOLD: begin
          if (w_hold_done_c) begin
            r_state       <= IDLE;
            r_hold_active <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_hold_active <= 1'b0;
        end
      endcase
    end
  end

  assign upd_ready    = w_upd_gnt;
  assign lkp_ready    = w_lkp_gnt;
  assign m_dataindex  = r_m_dataindex;
  assign m_user       = r_m_user;
  assign m_select     = r_m_select;
  assign m_valid      = r_m_valid;
  assign hold_active  = r_hold_active;
  assign starve_grant = r_starve_grant;

endmodule
